fp_denorm: RTL

FP_DENORM -- requirements
Module: fp_denorm

---
 rtl/fp_denorm.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fp_denorm.sv
// Aligns a packed IEEE-754 single to a caller-chosen exponent, one mantissa bit per clock.
// Define FP_DENORM_STICKY_EN to OR shifted-out bits into mant bit 0 instead of truncating.
module fp_denorm #(
  parameter int iWIDTH = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [iWIDTH-1:0] iNR,
  input  logic [7:0]        iTgtExp,
  input  logic              iValid,
  output logic              oReady,
  output logic [39:0]       oA,
  output logic              oValid,
  input  logic              iReady
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, stateNext;

  logic              sign_p0;
  logic [7:0]        exp_p0;
  logic [30:0]       mant_p0;
  logic [4:0]        cnt_p0;

  logic              inSign;
  logic [7:0]        inExp;
  logic [22:0]       inFrac;
  logic [30:0]       unpMant;
  logic [7:0]        effExp;
  logic signed [9:0] diff;
  logic [7:0]        loadExp;
  logic [30:0]       loadMant;
  logic [4:0]        loadCnt;
  logic              loadShift;

  function automatic logic [30:0] shiftOne(input logic [30:0] m);
    logic [30:0] r;
    r = {1'b0, m[30:1]};
`ifdef FP_DENORM_STICKY_EN
    r[0] = r[0] | m[0];
`endif
    return r;
  endfunction

  // Alignment beyond the mantissa width loses every bit at once.
  function automatic logic [30:0] flushAll(input logic [30:0] m);
    logic [30:0] r;
    r = '0;
`ifdef FP_DENORM_STICKY_EN
    r[0] = |m;
`else
    r[0] = 1'b0 & m[0];
`endif
    return r;
  endfunction

  assign inSign  = iNR[iWIDTH-1];
  assign inExp   = iNR[iWIDTH-2 -: 8];
  assign inFrac  = iNR[22:0];
  // Any nonzero exponent, including Inf/NaN, carries the hidden one.
  assign unpMant = {(inExp != 8'd0), inFrac, 7'b0};
  assign effExp  = (inExp == 8'd0) ? 8'd1 : inExp;
  assign diff    = $signed({2'b00, iTgtExp}) - $signed({2'b00, effExp});

  always_comb begin
    loadExp   = effExp;
    loadMant  = unpMant;
    loadCnt   = 5'd0;
    loadShift = 1'b0;
    if (inExp == 8'hFF) begin
      loadExp = 8'hFF;
    end else if (diff <= 10'sd0) begin
      loadExp = effExp;
    end else if (diff >= 10'sd32) begin
      loadExp  = iTgtExp;
      loadMant = flushAll(unpMant);
    end else begin
      loadCnt   = diff[4:0];
      loadShift = 1'b1;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iValid) stateNext = loadShift ? SHIFT : DONE;
      SHIFT:   if (cnt_p0 == 5'd1) stateNext = DONE;
      DONE:    if (iReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // ---- stage p0: unpack on accept, then iterative alignment ----
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sign_p0 <= 1'b0;
      exp_p0  <= 8'd0;
      mant_p0 <= 31'd0;
      cnt_p0  <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (iValid) begin
            sign_p0 <= inSign;
            exp_p0  <= loadExp;
            mant_p0 <= loadMant;
            cnt_p0  <= loadCnt;
          end
        end
        SHIFT: begin
          mant_p0 <= shiftOne(mant_p0);
          exp_p0  <= exp_p0 + 8'd1;
          cnt_p0  <= cnt_p0 - 5'd1;
        end
        default: ;
      endcase
    end
  end

  // ---- output: word is only meaningful while oValid is high ----
  assign oA     = {sign_p0, exp_p0, mant_p0};
  assign oValid = (state == DONE);
  assign oReady = (state == IDLE);

endmodule
